gen_equalizer: RTL

- Output-side counterpart of the acquisition equalizer: pre-distorts generator samples before the DAC to compensate the analog output chain.
- Pipelined AXI4-stream stage: gain (KK), offset (LS), first-order pre-emphasis (PE), then saturation to DAC width.
- Sits between the generator waveform/ASG stream and the DAC interface, in the ACLK domain.

---
 rtl/gen_equalizer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/gen_equalizer.sv
// -----------------------------------------------------------------------------
// gen_equalizer
//   Pre-distorts generator samples on their way to the DAC. The analog output
//   chain is compensated by a gain, an offset and a first-order pre-emphasis,
//   and the result is saturated to the DAC width. This is a three-stage
//   AXI4-stream pipeline in the ACLK domain with per-stage backpressure.
//
// Ports
//   ACLK        clock
//   ARESETn     synchronous active-low reset
//   cfg_kk      signed gain, unity = 2**14
//   cfg_ls      signed offset added after the gain, output LSB units
//   cfg_pe      signed pre-emphasis coefficient, 1.0 = 2**16
//   ctl_rst     synchronous clear of pipeline, history and saturation count
//   sti_*       input stream (tdata/tlast/tvalid/tready)
//   sto_*       output stream to the DAC (tdata/tlast/tvalid/tready)
//   sts_sat     number of clipped output samples, sticks at all-ones
// -----------------------------------------------------------------------------
module gen_equalizer #(
    parameter int DWI = 14,
    parameter int DWO = 14,
    parameter int CNT = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic signed [15:0]    cfg_kk,
    input  logic signed [13:0]    cfg_ls,
    input  logic signed [17:0]    cfg_pe,
    input  logic                  ctl_rst,
    input  logic signed [DWI-1:0] sti_tdata,
    input  logic                  sti_tlast,
    input  logic                  sti_tvalid,
    output logic                  sti_tready,
    output logic signed [DWO-1:0] sto_tdata,
    output logic                  sto_tlast,
    output logic                  sto_tvalid,
    input  logic                  sto_tready,
    output logic [CNT-1:0]        sts_sat
);

    localparam int PW  = DWI + 16;   // gain product
    localparam int S1W = DWI + 3;    // gain + offset result
    localparam int DW  = S1W + 1;    // history difference
    localparam int MW  = DW + 18;    // difference * coefficient
    localparam int S2W = S1W + 4;    // emphasised sample

    // Gain with floor rounding (arithmetic shift), then offset.
    function automatic logic signed [S1W-1:0] f_gain(
        input logic signed [DWI-1:0] x,
        input logic signed [15:0]    kk,
        input logic signed [13:0]    ls
    );
        logic signed [PW-1:0]  p;
        logic signed [PW-1:0]  q;
        p = PW'(x) * PW'(kk);
        q = p >>> 14;
        return $signed(q[S1W-1:0]) + S1W'(ls);
    endfunction

    // First-order pre-emphasis: s + pe * (s - h), floor rounding.
    function automatic logic signed [S2W-1:0] f_emph(
        input logic signed [S1W-1:0] s,
        input logic signed [S1W-1:0] h,
        input logic signed [17:0]    pe
    );
        logic signed [DW-1:0] d;
        logic signed [MW-1:0] m;
        logic signed [MW-1:0] ms;
        d  = DW'(s) - DW'(h);
        m  = MW'(d) * MW'(pe);
        ms = m >>> 16;
        return S2W'(s) + $signed(ms[S2W-1:0]);
    endfunction

    // Out of range when the bits above the DAC sign bit are not all equal.
    function automatic logic f_clips(input logic signed [S2W-1:0] v);
        logic [S2W-DWO:0] u;
        u = v[S2W-1:DWO-1];
        return !((&u) || !(|u));
    endfunction

    function automatic logic signed [DWO-1:0] f_sat(input logic signed [S2W-1:0] v);
        if (!f_clips(v))
            return v[DWO-1:0];
        else if (v[S2W-1])
            return {1'b1, {(DWO-1){1'b0}}};
        else
            return {1'b0, {(DWO-1){1'b1}}};
    endfunction

    logic                  r_vld_p1, r_vld_p2, r_vld_p3;
    logic                  r_last_p1, r_last_p2, r_last_p3;
    logic signed [S1W-1:0] r_s1_p1;
    logic signed [S2W-1:0] r_s2_p2;
    logic signed [DWO-1:0] r_dat_p3;
    logic signed [S1W-1:0] r_hist;
    logic [CNT-1:0]        r_sat_cnt;

    logic w_rdy_p1, w_rdy_p2, w_rdy_p3;
    logic w_clr;

    // A stage can accept when downstream can, or when it is empty.
    assign w_rdy_p3 = sto_tready | ~r_vld_p3;
    assign w_rdy_p2 = w_rdy_p3   | ~r_vld_p2;
    assign w_rdy_p1 = w_rdy_p2   | ~r_vld_p1;
    assign w_clr    = ~ARESETn | ctl_rst;

    always_ff @(posedge ACLK) begin
        if (w_clr) begin
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_vld_p3  <= 1'b0;
            r_last_p1 <= 1'b0;
            r_last_p2 <= 1'b0;
            r_last_p3 <= 1'b0;
            r_s1_p1   <= '0;
            r_s2_p2   <= '0;
            r_dat_p3  <= '0;
            r_hist    <= '0;
            r_sat_cnt <= '0;
        end else begin
            // S1: gain and offset
            if (w_rdy_p1) begin
                r_vld_p1 <= sti_tvalid;
                if (sti_tvalid) begin
                    r_s1_p1   <= f_gain(sti_tdata, cfg_kk, cfg_ls);
                    r_last_p1 <= sti_tlast;
                end
            end
            // S2: pre-emphasis against the previously accepted S1 sample
            if (w_rdy_p2) begin
                r_vld_p2 <= r_vld_p1;
                if (r_vld_p1) begin
                    r_s2_p2   <= f_emph(r_s1_p1, r_hist, cfg_pe);
                    r_hist    <= r_s1_p1;
                    r_last_p2 <= r_last_p1;
                end
            end
            // S3: saturation to DAC width
            if (w_rdy_p3) begin
                r_vld_p3 <= r_vld_p2;
                if (r_vld_p2) begin
                    r_dat_p3  <= f_sat(r_s2_p2);
                    r_last_p3 <= r_last_p2;
                    if (f_clips(r_s2_p2) && (r_sat_cnt != '1))
                        r_sat_cnt <= r_sat_cnt + CNT'(1);
                end
            end
        end
    end

    assign sti_tready = w_rdy_p1;
    assign sto_tdata  = r_dat_p3;
    assign sto_tlast  = r_last_p3;
    assign sto_tvalid = r_vld_p3;
    assign sts_sat    = r_sat_cnt;

endmodule
